spiker_result_fifo: RTL

Parametrised capture buffer between the spiking core's output vector and the software-visible result registers. It decimates the core's sample strobes, queues up to DEPTH captured spike vectors, presents the head entry as N_REG words of WIDTH bits, and raises status, event and interrupt signals. Software consumes an entry with a pop strobe. The adapter top maps the flat ports onto the hw2reg/reg2hw structs.

---
 rtl/spiker_result_fifo.sv | 109 ++++++++++
 1 files changed

// File: rtl/spiker_result_fifo.sv
// spiker_result_fifo: decimating capture queue from the spiking core output to the result registers
//
// Ports:
//   clk_i, rst_ni     clock and asynchronous active-low reset
//   clear_i           synchronous flush of queue, decimation counter, overflow and timestamp counter
//   data_i, sample_i  spike vector and its one-cycle sample strobe
//   ready_i           core ready status, mirrored on status_ready_o
//   decim_i           store one of every decim_i+1 samples
//   irq_thresh_i      level interrupt threshold, 0 disables the interrupt
//   pop_i             consumes the head entry
//   writer_ready_o    queue not full
//   result_o          zero-padded head entry, all zeros when empty
//   valid_o, level_o  queue not empty, number of queued entries
//   overflow_o        sticky: a store was dropped because the queue was full
//   sample_event_o    one-cycle pulse after each successful store
//   irq_o             level interrupt
//   timestamp_o       capture cycle of the head entry
//
// Optional feature: define SPIKER_RESULT_TIMESTAMP_EN to keep a capture cycle stamp per entry;
// without it timestamp_o is tied to 0.
module spiker_result_fifo #(
  parameter int WIDTH      = 32,
  parameter int DATA_WIDTH = 800,
  parameter int N_REG      = 25,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic [DATA_WIDTH-1:0]       data_i,
  input  logic                        sample_i,
  input  logic                        ready_i,
  input  logic [CNT_W-1:0]            decim_i,
  input  logic [CNT_W-1:0]            irq_thresh_i,
  input  logic                        pop_i,
  output logic                        writer_ready_o,
  output logic                        status_ready_o,
  output logic [N_REG*WIDTH-1:0]      result_o,
  output logic                        valid_o,
  output logic [$clog2(DEPTH):0]      level_o,
  output logic                        overflow_o,
  output logic                        sample_event_o,
  output logic                        irq_o,
  output logic [31:0]                 timestamp_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [LW-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      dec_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  full, empty, store_try, do_pop, do_store;
  // pointers carry a wrap bit: equal means empty, differing only in the MSB means full
  assign empty     = wr_ptr == rd_ptr;
  assign full      = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  // >= rather than == so a decim_i lowered below the running count fires on the next sample
  assign store_try = sample_i && (dec_cnt >= decim_i);
  assign do_pop    = !clear_i && pop_i && !empty;
  // a pop in the same cycle frees the slot the store needs
  assign do_store  = !clear_i && store_try && (!full || do_pop);
  assign writer_ready_o = !full;
  assign status_ready_o = ready_i;
  assign valid_o        = !empty;
  assign level_o        = wr_ptr - rd_ptr;
  assign irq_o          = (irq_thresh_i != '0) && (32'(level_o) >= 32'(irq_thresh_i));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      dec_cnt        <= '0;
      overflow_o     <= 1'b0;
      sample_event_o <= 1'b0;
    end else if (clear_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      dec_cnt        <= '0;
      overflow_o     <= 1'b0;
      sample_event_o <= 1'b0;
    end else begin
      if (sample_i) dec_cnt <= store_try ? '0 : dec_cnt + CNT_W'(1);
      if (do_store) wr_ptr <= wr_ptr + LW'(1);
      if (do_pop) rd_ptr <= rd_ptr + LW'(1);
      if (store_try && !do_store) overflow_o <= 1'b1;
      sample_event_o <= do_store;
    end
  end
  // storage has no reset: contents are only visible through valid pointers
  always_ff @(posedge clk_i) begin
    if (do_store) mem[wr_ptr[AW-1:0]] <= data_i;
  end
  always_comb begin
    result_o = '0;
    if (!empty) result_o[DATA_WIDTH-1:0] = mem[rd_ptr[AW-1:0]];
  end
`ifdef SPIKER_RESULT_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] ts_mem [DEPTH];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ts_cnt <= '0;
    else ts_cnt <= clear_i ? '0 : ts_cnt + 32'd1;
  end
  always_ff @(posedge clk_i) begin
    if (do_store) ts_mem[wr_ptr[AW-1:0]] <= ts_cnt;
  end
  assign timestamp_o = empty ? '0 : ts_mem[rd_ptr[AW-1:0]];
`else
  assign timestamp_o = '0;
`endif
endmodule
